uart_autobaud_ctrl: RTL
=======================

Name: uart_autobaud_ctrl

Overview:
Automatic baud-rate controller for the multi-baud UART byte receiver. It drives the receiver's 3-bit baud_set, steps through the eight candidate rates, and watches received bytes for a repeated sync pattern (default 0x55). After a configurable number of consecutive matches it locks the rate, then forwards later bytes to the downstream command/FIFO logic. Sits between the receiver (rx_data/rx_done) and the protocol layer.

Parameters:
SYNC_BYTE, 8'h55, sync character expected during hunt
SYNC_COUNT, 3, consecutive SYNC_BYTE receptions required to lock (1..15)
START_IDX, 3'd0, first candidate baud_set after reset/relock
SETTLE_CYC, 10000, Clk cycles to ignore rx_done after every baud_set change
TIMEOUT_CYC, 2000000, Clk cycles without rx_done before advancing candidate (40 ms @ 50 MHz)

Ports:
Clk  input  1  system clock, 50 MHz
Rst_n  input  1  asynchronous active-low reset
enable  input  1  1 = run controller; 0 = force IDLE
relock  input  1  single-cycle pulse: drop lock, restart hunt at START_IDX
rx_data  input  8  byte from receiver, valid when rx_done=1
rx_done  input  1  single-cycle byte-complete strobe from receiver
baud_set  output  3  rate select to receiver, registered
locked  output  1  1 while in LOCKED
byte_out  output  8  forwarded byte, registered
byte_valid  output  1  single-cycle strobe with byte_out, LOCKED only
sweep_fail  output  1  single-cycle pulse when all 8 candidates tried without lock

Behaviour:
- Reset: baud_set=START_IDX, locked=0, byte_out=0, byte_valid=0, sweep_fail=0, state=IDLE, all counters 0.
- States: IDLE, SETTLE, HUNT, LOCKED.
- IDLE: baud_set held, locked=0. enable=1 -> SETTLE with baud_set=START_IDX, match_cnt=0, tried_cnt=0.
- SETTLE: settle_cnt counts 0..SETTLE_CYC-1; rx_done ignored; at terminal count -> HUNT, timeout_cnt=0.
- HUNT: timeout_cnt increments each cycle, cleared on any rx_done.
  - rx_done with rx_data==SYNC_BYTE: match_cnt+1; reaching SYNC_COUNT -> LOCKED, locked=1 next cycle. The lock byte itself is not forwarded.
  - rx_done with rx_data!=SYNC_BYTE: ADVANCE.
  - timeout_cnt reaches TIMEOUT_CYC-1 with no rx_done: ADVANCE.
- ADVANCE (action, not a state): baud_set <= baud_set+1 mod 8 (7 wraps to 0); match_cnt=0; tried_cnt+1; -> SETTLE. When tried_cnt reaches 8, pulse sweep_fail one cycle, clear tried_cnt, and keep hunting (no stop).
- LOCKED: baud_set frozen. Each rx_done -> byte_out=rx_data, byte_valid=1 on the next cycle (latency 1 Clk). No timeout in LOCKED; idle lines keep the lock.
- relock (any state except IDLE): -> SETTLE, baud_set=START_IDX, locked=0 next cycle, counters cleared. If relock and rx_done happen in the same cycle, relock wins and the byte is dropped.
- enable=0 in any state -> IDLE next cycle, locked=0, no byte_valid. Takes priority over relock.
- Priority each cycle: enable=0 > relock > rx_done > timeout.
- byte_valid and sweep_fail are never asserted for more than 1 consecutive cycle from a single event.
- rx_done during SETTLE never changes match_cnt, timeout_cnt or byte_out.
- Counter widths are sized with $clog2 of their parameter; no wrap beyond the terminal count.
- Async reset mid-operation: immediate return to reset values. No partial-state retention.

Test Plan:
- Reset, enable=1, drive 3x 0x55 at baud_set=0 timing after SETTLE -> locked=1 one cycle after the 3rd rx_done, baud_set=0, no byte_valid for the sync bytes.
- Line actually at idx 4: send 0x55 repeatedly; each wrong-rate idx gets garbage bytes or timeout -> baud_set steps 0,1,2,3,4 (each after SETTLE_CYC plus mismatch/timeout), locks at 4.
- Silent line, small params (SETTLE_CYC=4, TIMEOUT_CYC=16) -> baud_set advances every 20 cycles, wraps 7->0, sweep_fail pulses once per 8 advances.
- Locked at idx 2, send 0xA5, 0x00 -> byte_valid pulses twice, byte_out=0xA5 then 0x00, each 1 cycle after rx_done.
- Locked, relock pulse coincident with rx_done(0x3C) -> no byte_valid, locked=0 next cycle, baud_set=START_IDX, SETTLE restarts.
- Mid-hunt with 2 matches, 0x54 received -> match_cnt cleared, baud_set+1; enable=0 any time -> IDLE, locked=0; Rst_n low -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_autobaud_ctrl_if.sv
// Receiver-side and downstream byte link of the autobaud controller.
// The slave modport is the controller; the master modport is the receiver/sink side.
interface uart_autobaud_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [2:0] baud_set;
  logic [7:0] byte_out;
  logic       byte_valid;

  modport master (
    output rx_data, rx_done,
    input  baud_set, byte_out, byte_valid
  );

  modport slave (
    input  rx_data, rx_done,
    output baud_set, byte_out, byte_valid
  );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Automatic baud-rate hunt: sweeps baud_set until SYNC_COUNT consecutive
// SYNC_BYTE receptions are seen, then locks and forwards received bytes.
module uart_autobaud_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'h55,
  parameter int unsigned SYNC_COUNT  = 3,
  parameter logic [2:0]  START_IDX   = 3'd0,
  parameter int unsigned SETTLE_CYC  = 10000,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 enable,
  input  logic                 relock,
  uart_autobaud_ctrl_if.slave  bus,
  output logic                 locked,
  output logic                 sweep_fail
);

  localparam int unsigned SW = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned MW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HUNT, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] settle_cnt, settle_nxt;
  logic [TW-1:0] timeout_cnt, timeout_nxt;
  logic [MW-1:0] match_cnt, match_nxt;
  logic [2:0]    tried_cnt, tried_nxt;
  logic [2:0]    baud_nxt;
  logic [7:0]    byte_nxt;
  logic          valid_nxt, fail_nxt, locked_nxt;
  logic          is_sync, settle_done, timeout_hit, match_done, advance;

  assign is_sync     = (bus.rx_data == SYNC_BYTE);
  assign settle_done = (settle_cnt  == SW'(SETTLE_CYC - 1));
  assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYC - 1));
  assign match_done  = (match_cnt   == MW'(SYNC_COUNT - 1));
  assign advance     = (state == HUNT) && (bus.rx_done ? !is_sync : timeout_hit);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = HUNT;
      HUNT: begin
        if (advance)                        state_nxt = SETTLE;
        else if (bus.rx_done && match_done) state_nxt = LOCKED;
      end
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = IDLE;
    endcase
    // enable=0 outranks relock, which outranks any byte or timeout event
    if (relock && state != IDLE) state_nxt = SETTLE;
    if (!enable)                 state_nxt = IDLE;
  end

  always_comb begin
    settle_nxt  = settle_cnt;
    timeout_nxt = timeout_cnt;
    match_nxt   = match_cnt;
    tried_nxt   = tried_cnt;
    baud_nxt    = bus.baud_set;
    byte_nxt    = bus.byte_out;
    valid_nxt   = 1'b0;
    fail_nxt    = 1'b0;
    locked_nxt  = (state_nxt == LOCKED);
    if (!enable) begin
      // hold everything; the restart from IDLE clears the counters
    end else if (state == IDLE || relock) begin
      settle_nxt  = '0;
      timeout_nxt = '0;
      match_nxt   = '0;
      tried_nxt   = '0;
      baud_nxt    = START_IDX;
    end else begin
      unique case (state)
        SETTLE: begin
          settle_nxt = settle_done ? '0 : settle_cnt + 1'b1;
          if (settle_done) timeout_nxt = '0;
        end
        HUNT: begin
          if (advance) begin
            baud_nxt    = bus.baud_set + 3'd1;
            match_nxt   = '0;
            settle_nxt  = '0;
            timeout_nxt = '0;
            fail_nxt    = (tried_cnt == 3'd7);
            tried_nxt   = tried_cnt + 3'd1;
          end else if (bus.rx_done) begin
            timeout_nxt = '0;
            match_nxt   = match_done ? '0 : match_cnt + 1'b1;
          end else begin
            timeout_nxt = timeout_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (bus.rx_done) begin
            byte_nxt  = bus.rx_data;
            valid_nxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      settle_cnt     <= '0;
      timeout_cnt    <= '0;
      match_cnt      <= '0;
      tried_cnt      <= '0;
      bus.baud_set   <= START_IDX;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      sweep_fail     <= 1'b0;
      locked         <= 1'b0;
    end else begin
      settle_cnt     <= settle_nxt;
      timeout_cnt    <= timeout_nxt;
      match_cnt      <= match_nxt;
      tried_cnt      <= tried_nxt;
      bus.baud_set   <= baud_nxt;
      bus.byte_out   <= byte_nxt;
      bus.byte_valid <= valid_nxt;
      sweep_fail     <= fail_nxt;
      locked         <= locked_nxt;
    end
  end

endmodule
